// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the execute-stage controller and alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
);
  logic start;
  logic [5:0] alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0] shamt;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic zero;
  logic overflow;
  logic illegal;
  modport master (
    output start, alucontrol, a, b, shamt,
    input busy, done, result, zero, overflow, illegal
  );
  modport slave (
    input start, alucontrol, a, b, shamt,
    output busy, done, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multicycle integer ALU with a one-bit-per-cycle iterative shifter
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input logic clk,
  input logic reset,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [5:0] op;
  logic [WIDTH-1:0] work, shifted, bx, sum, res;
  logic [SHW-1:0] cnt;
  logic ovf, ov, legal, is_shift, accept;
  // bit 5 of the code selects inverted B with carry-in, shared by SUB and SLT
  assign bx = bus.alucontrol[5] ? ~bus.b : bus.b;
  assign sum = bus.a + bx + {{(WIDTH-1){1'b0}}, bus.alucontrol[5]};
  assign ovf = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign is_shift = bus.alucontrol == 6'b001000 || bus.alucontrol == 6'b001010 ||
                    bus.alucontrol == 6'b001011;
  assign accept = state == IDLE && bus.start;
  assign shifted = op == 6'b001000 ? {work[WIDTH-2:0], 1'b0} :
                   {op == 6'b001011 ? work[WIDTH-1] : 1'b0, work[WIDTH-1:1]};
  assign bus.busy = state == BUSY;
  assign bus.done = state == DONE;
  always_comb begin
    res = '0;
    ov = 1'b0;
    legal = 1'b1;
    case (bus.alucontrol)
      6'b000000: res = bus.a & bus.b;
      6'b000001: res = bus.a | bus.b;
      6'b000100: res = bus.a ^ bus.b;
      6'b000101: res = ~(bus.a | bus.b);
      6'b000010, 6'b100010: begin
        res = sum;
        ov = ovf;
      end
      6'b100011: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      6'b001000, 6'b001010, 6'b001011: res = bus.a;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (is_shift && bus.shamt != '0 ? BUSY : DONE) : IDLE;
      BUSY: state_n = cnt == SHW'(1) ? DONE : BUSY;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      work <= '0;
      cnt <= '0;
      bus.result <= '0;
      bus.zero <= 1'b1;
      bus.overflow <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= bus.alucontrol;
        work <= bus.a;
        cnt <= bus.shamt;
        bus.overflow <= 1'b0;
        bus.illegal <= 1'b0;
        if (state_n == DONE) begin
          bus.result <= res;
          bus.zero <= res == '0;
          bus.overflow <= ov;
          bus.illegal <= ~legal;
        end
      end
      if (state == BUSY) begin
        work <= shifted;
        cnt <= cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          bus.result <= shifted;
          bus.zero <= shifted == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand sequences for ignored start and mid-shift reset
module tb_alu_seq;
  typedef struct {
    logic [5:0] code;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] sh;
    logic [31:0] res;
    logic z;
    logic o;
    logic i;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  vec_t v[16];
  alu_seq_if #(.WIDTH(32), .SHW(5)) bus ();
  alu_seq #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.start = 1'b1;
    bus.alucontrol = code;
    bus.a = a;
    bus.b = b;
    bus.shamt = sh;
  endtask
  // accept one op, optionally poke a conflicting start in cycle 2, then check latency and outputs
  task automatic run(input vec_t t, input string tag, input bit poke);
    int k;
    bit got, bsy_ok;
    @(negedge clk);
    drive(t.code, t.a, t.b, t.sh);
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    got = 0;
    bsy_ok = 1;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (poke && k == 2) drive(6'b000001, 32'h1234_5678, 32'h0000_ffff, 5'd1);
      if (poke && k == 3) bus.start = 1'b0;
      if (bus.done) got = 1;
      else if (!bus.busy) bsy_ok = 0;
    end
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, k, t.lat);
    chk({tag, " busy_until_done"}, 32'(bsy_ok), 32'd1);
    chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, " result"}, bus.result, t.res);
    chk({tag, " zero"}, 32'(bus.zero), 32'(t.z));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(t.o));
    chk({tag, " illegal"}, 32'(bus.illegal), 32'(t.i));
  endtask
  initial begin
    int k;
    bit seen;
    v[0]  = '{6'b000010, 32'h7fffffff, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1};
    v[1]  = '{6'b100010, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v[2]  = '{6'b100011, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    v[3]  = '{6'b100011, 32'h80000000, 32'h7fffffff, 5'd0, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    v[4]  = '{6'b001011, 32'h80000010, 32'h0, 5'd4, 32'hf8000001, 1'b0, 1'b0, 1'b0, 5};
    v[5]  = '{6'b001010, 32'h80000010, 32'h0, 5'd4, 32'h08000001, 1'b0, 1'b0, 1'b0, 5};
    v[6]  = '{6'b001000, 32'h00000001, 32'h0, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 32};
    v[7]  = '{6'b001000, 32'h00001234, 32'h0, 5'd0, 32'h00001234, 1'b0, 1'b0, 1'b0, 1};
    v[8]  = '{6'b111111, 32'h12345678, 32'h9, 5'd3, 32'h00000000, 1'b1, 1'b0, 1'b1, 1};
    v[9]  = '{6'b000000, 32'h0000f0f0, 32'h0000ff00, 5'd0, 32'h0000f000, 1'b0, 1'b0, 1'b0, 1};
    v[10] = '{6'b000100, 32'hff00ff00, 32'h0f0f0f0f, 5'd0, 32'hf00ff00f, 1'b0, 1'b0, 1'b0, 1};
    v[11] = '{6'b000101, 32'h00000000, 32'h0000000f, 5'd0, 32'hfffffff0, 1'b0, 1'b0, 1'b0, 1};
    v[12] = '{6'b100010, 32'h80000000, 32'h00000001, 5'd0, 32'h7fffffff, 1'b0, 1'b1, 1'b0, 1};
    v[13] = '{6'b100011, 32'h00000001, 32'hffffffff, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v[14] = '{6'b000010, 32'hffffffff, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
    v[15] = '{6'b001011, 32'h40000000, 32'h0, 5'd1, 32'h20000000, 1'b0, 1'b0, 1'b0, 2};
    drive(6'b000010, 32'h1, 32'h1, 5'd0);
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", bus.result, 32'h0);
    chk("reset zero", 32'(bus.zero), 32'd1);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset overflow", 32'(bus.overflow), 32'd0);
    chk("reset illegal", 32'(bus.illegal), 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) run(v[i], $sformatf("vec%0d", i), 1'b0);
    run(v[4], "sra_poke", 1'b1);
    @(negedge clk);
    chk("idle_after_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    drive(6'b001000, 32'h00000001, 32'h0, 5'd10);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midshift busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort result", bus.result, 32'h0);
    chk("abort zero", 32'(bus.zero), 32'd1);
    seen = 0;
    for (k = 0; k < 12; k++) begin
      if (bus.done) seen = 1;
      @(negedge clk);
    end
    chk("abort no_done", 32'(seen), 32'd0);
    run('{6'b000001, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0, 1'b0, 1'b0, 1}, "or_after_reset", 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
